// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART-driven ALU controller: FSM state encoding
// and default operand/opcode widths.
package alu_uart_pkg;

  localparam int NB_DATA_DEF = 8;
  localparam int NB_OP_DEF   = 6;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GET_B   = 3'd1;
  localparam logic [2:0] ST_GET_OP  = 3'd2;
  localparam logic [2:0] ST_COMPUTE = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    GET_B   = ST_GET_B,
    GET_OP  = ST_GET_OP,
    COMPUTE = ST_COMPUTE,
    SEND    = ST_SEND,
    WAIT_TX = ST_WAIT_TX
  } state_t;

endpackage

// File: rtl/alu_uart_ctrl_frame_timer.sv
// Inter-byte idle timer (module frame_timer). Only built when
// ALU_UART_CTRL_TIMEOUT_EN is defined, the only configuration that uses it.
`ifdef ALU_UART_CTRL_TIMEOUT_EN
module frame_timer #(
  parameter int TIMEOUT_CYC = 50_000_000
)(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_count;

  assign o_expired = i_enable && (r_count == CNT_W'(TIMEOUT_CYC - 1));

  // A clear on the expiry cycle takes priority, so a late byte still restarts the window.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear || o_expired) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/alu_uart_ctrl.sv
// Collects A, B, opcode bytes from a UART receiver, drives an external ALU and
// sends the result back. Optional inter-byte timeout: ALU_UART_CTRL_TIMEOUT_EN.
module alu_uart_ctrl
  import alu_uart_pkg::*;
#(
  parameter int NB_DATA     = NB_DATA_DEF,
  parameter int NB_OP       = NB_OP_DEF,
  parameter int TIMEOUT_CYC = 50_000_000
)(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_rx_done_data,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_busy,
  output logic               o_drop
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NB_DATA-1:0] r_alu_a;
  logic [NB_DATA-1:0] r_alu_b;
  logic [NB_OP-1:0]   r_alu_op;
  logic [NB_DATA-1:0] r_tx_data;
  logic               r_drop;
  logic               w_ld_a;
  logic               w_ld_b;
  logic               w_ld_op;
  logic               w_ld_tx;
  logic               w_tx_start;
  logic               w_drop_nxt;
  logic               w_accept;
  logic               w_timeout;

  assign w_accept = w_ld_a || w_ld_b || w_ld_op;

`ifdef ALU_UART_CTRL_TIMEOUT_EN
  logic w_tmr_en;

  assign w_tmr_en = (r_state == GET_B) || (r_state == GET_OP);

  frame_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_frame_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (w_accept),
    .i_enable  (w_tmr_en),
    .o_expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A received byte is checked before the timeout so a byte on the expiry cycle wins.
  always_comb begin
    w_state_nxt = r_state;
    w_ld_a      = 1'b0;
    w_ld_b      = 1'b0;
    w_ld_op     = 1'b0;
    w_ld_tx     = 1'b0;
    w_tx_start  = 1'b0;
    w_drop_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_rx_done_data) begin
          w_ld_a      = 1'b1;
          w_state_nxt = GET_B;
        end
      end
      GET_B: begin
        if (i_rx_done_data) begin
          w_ld_b      = 1'b1;
          w_state_nxt = GET_OP;
        end else if (w_timeout) begin
          w_drop_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      GET_OP: begin
        if (i_rx_done_data) begin
          w_ld_op     = 1'b1;
          w_state_nxt = COMPUTE;
        end else if (w_timeout) begin
          w_drop_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      COMPUTE: begin
        w_ld_tx     = 1'b1;
        w_drop_nxt  = i_rx_done_data;
        w_state_nxt = SEND;
      end
      SEND: begin
        w_tx_start  = 1'b1;
        w_drop_nxt  = i_rx_done_data;
        w_state_nxt = WAIT_TX;
      end
      WAIT_TX: begin
        w_drop_nxt = i_rx_done_data;
        if (i_tx_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operands persist across frames; only a newly accepted byte replaces them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_tx_data <= '0;
      r_drop    <= 1'b0;
    end else begin
      if (w_ld_a) begin
        r_alu_a <= i_rx_data;
      end
      if (w_ld_b) begin
        r_alu_b <= i_rx_data;
      end
      if (w_ld_op) begin
        r_alu_op <= i_rx_data[NB_OP-1:0];
      end
      if (w_ld_tx) begin
        r_tx_data <= i_alu_result;
      end
      r_drop <= w_drop_nxt;
    end
  end

  assign o_tx_start = w_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_alu_a    = r_alu_a;
  assign o_alu_b    = r_alu_b;
  assign o_alu_op   = r_alu_op;
  assign o_busy     = (r_state != IDLE);
  assign o_drop     = r_drop;

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl with a small behavioural ALU model;
// timeout expectations follow ALU_UART_CTRL_TIMEOUT_EN.
module tb_alu_uart_ctrl;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TCYC    = 100;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               rx_done = 1'b0;
  logic [NB_DATA-1:0] rx_data = '0;
  logic               tx_done = 1'b0;
  logic [NB_DATA-1:0] alu_result;
  logic               tx_start;
  logic [NB_DATA-1:0] tx_data;
  logic [NB_DATA-1:0] alu_a;
  logic [NB_DATA-1:0] alu_b;
  logic [NB_OP-1:0]   alu_op;
  logic               busy;
  logic               drop;

  int n_chk = 0;
  int n_bad = 0;
  int n_start = 0;

  alu_uart_ctrl #(
    .NB_DATA     (NB_DATA),
    .NB_OP       (NB_OP),
    .TIMEOUT_CYC (TCYC)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rx_done_data (rx_done),
    .i_rx_data      (rx_data),
    .i_tx_done      (tx_done),
    .i_alu_result   (alu_result),
    .o_tx_start     (tx_start),
    .o_tx_data      (tx_data),
    .o_alu_a        (alu_a),
    .o_alu_b        (alu_b),
    .o_alu_op       (alu_op),
    .o_busy         (busy),
    .o_drop         (drop)
  );

  always #5 clk = ~clk;

  // Model ALU: 0x20 ADD, 0x22 SUB, anything else AND.
  always_comb begin
    case (alu_op)
      6'h20:   alu_result = alu_a + alu_b;
      6'h22:   alu_result = alu_a - alu_b;
      default: alu_result = alu_a & alu_b;
    endcase
  end

  always @(posedge clk) begin
    if (tx_start) n_start++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic tx_done_pulse(input string tag);
    @(posedge clk); #1;
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
    @(negedge clk);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic finish_frame(input string tag, input logic [7:0] b, input logic [7:0] opb,
                              input logic [7:0] exp);
    int s0;
    s0 = n_start;
    send_byte(b);
    send_byte(opb);
    @(negedge clk);
    chk({tag, "_start_c1"}, tx_start, 0);
    @(negedge clk);
    chk({tag, "_start_c2"}, tx_start, 1);
    chk({tag, "_txdata"}, tx_data, exp);
    @(negedge clk);
    chk({tag, "_start_c3"}, tx_start, 0);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_nstart"}, n_start - s0, 1);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] opb, input logic [7:0] exp);
    send_byte(a);
    finish_frame(tag, b, opb, exp);
  endtask

  initial begin
    int s0;
    int bad_stab;
    int first;

    #1 rst = 1'b1;
    #2;
    chk("rst_txstart", tx_start, 0);
    chk("rst_txdata", tx_data, 0);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    do_frame("add", 8'h05, 8'h03, 8'h20, 8'h08);
    chk("add_a", alu_a, 8'h05);
    chk("add_b", alu_b, 8'h03);
    chk("add_op", alu_op, 6'h20);

    s0 = n_start;
    send_byte(8'hAA);
    @(negedge clk);
    chk("wait_drop_hi", drop, 1);
    chk("wait_drop_a", alu_a, 8'h05);
    @(negedge clk);
    chk("wait_drop_lo", drop, 0);
    tx_done_pulse("wait");
    chk("wait_nstart", n_start - s0, 0);

    send_byte(8'h03);
    @(posedge clk); #1 tx_done = 1'b1;
    @(posedge clk); #1 tx_done = 1'b0;
    @(negedge clk);
    chk("early_txdone_busy", busy, 1);
    finish_frame("opmask", 8'h06, 8'hE0, 8'h09);
    chk("opmask_op", alu_op, 6'h20);
    tx_done_pulse("opmask");

    send_byte(8'h05);
    send_byte(8'h03);
    s0 = n_start;
    #1 rst = 1'b1;
    #1;
    chk("midrst_a", alu_a, 0);
    chk("midrst_b", alu_b, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_txdata", tx_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_nostart", n_start - s0, 0);
    chk("midrst_idle", busy, 0);
    do_frame("sub", 8'h0F, 8'h01, 8'h22, 8'h0E);
    tx_done_pulse("sub");

    do_frame("b2b1", 8'h10, 8'h20, 8'h20, 8'h30);
    bad_stab = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_data !== 8'h30 || busy !== 1'b1) bad_stab++;
    end
    chk("b2b_stable", bad_stab, 0);
    tx_done_pulse("b2b1");
    do_frame("b2b2", 8'h40, 8'h01, 8'h22, 8'h3F);
    tx_done_pulse("b2b2");

    send_byte(8'h05);
    first = 0;
    for (int i = 1; i <= 120; i++) begin
      @(posedge clk); #1;
      if (drop && first == 0) first = i;
    end
`ifdef ALU_UART_CTRL_TIMEOUT_EN
    chk("tmo_drop_cycle", first, TCYC);
    chk("tmo_idle", busy, 0);
    send_byte(8'h07);
    chk("tmo_reload_a", alu_a, 8'h07);
`else
    chk("notmo_nodrop", first, 0);
`endif
    chk("tmo_getb_busy", busy, 1);
    repeat (TCYC - 2) @(posedge clk);
    send_byte(8'h09);
    @(negedge clk);
    chk("edge_nodrop", drop, 0);
    chk("edge_b", alu_b, 8'h09);
    chk("edge_busy", busy, 1);
    s0 = n_start;
    send_byte(8'h20);
    repeat (3) @(negedge clk);
    chk("edge_nstart", n_start - s0, 1);
    tx_done_pulse("edge");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_uart_ctrl.md
ALU_UART_CTRL -- requirements
Module: alu_uart_ctrl

Interface
REQ-001 SHALL have parameter NB_DATA, default 8, data/operand/result width in bits.
REQ-002 SHALL have parameter NB_OP, default 6, opcode width in bits (opcode = low NB_OP bits of third byte).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50_000_000, max idle clocks between bytes of one frame.
REQ-004 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_rx_done_data  input  1  one-cycle pulse: received byte valid.
REQ-007 SHALL have port i_rx_data  input  NB_DATA  received byte, valid with i_rx_done_data.
REQ-008 SHALL have port i_tx_done  input  1  one-cycle pulse: transmitter finished stop bit.
REQ-009 SHALL have port i_alu_result  input  NB_DATA  combinational ALU result for o_alu_a/b/op.
REQ-010 SHALL have port o_tx_start  output  1  one-cycle pulse requesting transmission.
REQ-011 SHALL have port o_tx_data  output  NB_DATA  byte to transmit, stable from o_tx_start until i_tx_done.
REQ-012 SHALL have port o_alu_a  output  NB_DATA  registered operand A.
REQ-013 SHALL have port o_alu_b  output  NB_DATA  registered operand B.
REQ-014 SHALL have port o_alu_op  output  NB_OP  registered opcode.
REQ-015 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port o_drop  output  1  one-cycle pulse: received byte discarded.

Function
REQ-017 SHALL implement FSM states IDLE, GET_B, GET_OP, COMPUTE, SEND, WAIT_TX.
REQ-018 IDLE: on i_rx_done_data SHALL load o_alu_a <= i_rx_data, go GET_B.
REQ-019 GET_B: on i_rx_done_data SHALL load o_alu_b, go GET_OP.
REQ-020 GET_OP: on i_rx_done_data SHALL load o_alu_op <= i_rx_data[NB_OP-1:0], go COMPUTE.
REQ-021 COMPUTE: SHALL latch i_alu_result into o_tx_data (one cycle), go SEND.
REQ-022 SEND: SHALL assert o_tx_start for exactly one cycle, go WAIT_TX.
REQ-023 WAIT_TX: on i_tx_done SHALL go IDLE; o_tx_start SHALL stay low.
REQ-024 Latency: o_tx_start SHALL assert exactly 2 cycles after the cycle GET_OP samples i_rx_done_data.
REQ-025 i_rx_done_data in COMPUTE, SEND or WAIT_TX SHALL be ignored and SHALL pulse o_drop the next cycle.
REQ-026 i_tx_done outside WAIT_TX SHALL be ignored.
REQ-027 o_alu_a/b/op SHALL hold their values until overwritten by a new frame; no clearing on IDLE return.
REQ-028 Opcode bits above NB_OP SHALL be discarded without error.

Reset
REQ-029 While i_rst high: state=IDLE; o_tx_start=0, o_tx_data=0, o_alu_a=0, o_alu_b=0, o_alu_op=0, o_busy=0, o_drop=0, timer=0.
REQ-030 Reset asserted mid-frame or mid-transmission SHALL abandon the frame; no o_tx_start after release until a new full frame arrives.

Configuration
REQ-031 Macro ALU_UART_CTRL_TIMEOUT_EN defined: counter reloads on every accepted byte, counts in GET_B/GET_OP; reaching TIMEOUT_CYC-1 SHALL return to IDLE and pulse o_drop.
REQ-032 Timeout and i_rx_done_data in the same cycle: byte SHALL win, counter reloads, no o_drop.
REQ-033 Macro undefined: no counter logic; GET_B/GET_OP wait indefinitely.

Structure
REQ-034 Shared package alu_uart_pkg SHALL hold FSM state encoding (localparams, 3 bits) and default NB_DATA/NB_OP.
REQ-035 Timeout counter SHALL be sub-module frame_timer (inputs clear, enable; output expired), instantiated only under ALU_UART_CTRL_TIMEOUT_EN.
REQ-036 ALU is external; this block SHALL contain no arithmetic other than the timer.

Verification
REQ-037 Bytes 0x05,0x03,0x20, model ALU ADD -> o_alu_a=0x05,o_alu_b=0x03,o_alu_op=0x20, o_tx_data=0x08, one o_tx_start 2 cycles after third byte.
REQ-038 Byte 0xAA during WAIT_TX -> o_drop one pulse, o_alu_a unchanged, no second o_tx_start.
REQ-039 i_rst pulsed after 0x05,0x03 -> all outputs 0; then 0x0F,0x01,0x22 (SUB) -> o_tx_data=0x0E.
REQ-040 TIMEOUT_EN, TIMEOUT_CYC=100: 0x05 then 120 idle cycles -> o_drop at cycle 100, state IDLE; next byte loads o_alu_a.
REQ-041 TIMEOUT_EN: byte arriving on expiry cycle -> accepted, no o_drop; without macro same stimulus waits indefinitely.
REQ-042 Back-to-back frames, i_tx_done delayed 1000 cycles -> o_tx_data stable throughout, o_busy high until i_tx_done.
